// File: rtl/mips_pkg.sv
// Opcode/funct encodings and FSM states shared by the MIPS-subset cores and their benches.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_RTYPE: ok = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_SRL, FN_JR};
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/multicycle_mips_core_if.sv
// Instruction and data memory handshake bundle; master = core, slave = memory side.
interface multicycle_mips_core_if #(
    parameter int DADDR_W = 7
);
    logic               imem_req;
    logic [31:0]        imem_addr;
    logic [31:0]        imem_rdata;
    logic               imem_valid;
    logic               dmem_cen;
    logic               dmem_wen;
    logic               dmem_oen;
    logic [DADDR_W-1:0] dmem_a;
    logic [31:0]        dmem_wdata;
    logic [31:0]        dmem_rdata;
    logic               dmem_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata, imem_valid,
        output dmem_cen, dmem_wen, dmem_oen, dmem_a, dmem_wdata,
        input  dmem_rdata, dmem_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata, imem_valid,
        input  dmem_cen, dmem_wen, dmem_oen, dmem_a, dmem_wdata,
        output dmem_rdata, dmem_ready
    );
endinterface

// File: rtl/mc_regfile.sv
// 32x32 GPR file: two asynchronous read ports, one synchronous write port, $0 reads as zero.
module mc_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] regs [32];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];
endmodule

// File: rtl/multicycle_mips_core.sv
// Multi-cycle MIPS-subset core; one FSM serialises fetch, decode, execute, memory and writeback.
//  state    | meaning
//  S_FETCH  | imem_req high, wait for imem_valid, latch IR
//  S_DECODE | latch A, B and sign-extended immediate
//  S_EXEC   | ALU, branch/jump resolve and retire, or set up memory access
//  S_MEM    | enables held low from registers until dmem_ready
//  S_WB     | GPR write, PC commit, retire
module multicycle_mips_core
    import mips_pkg::*;
#(
    parameter int          DADDR_W  = 7,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          CNT_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_mips_core_if.master bus,
    output logic [CNT_W-1:0]       instret,
    output logic                   illegal
);
    state_t             state, state_nx;
    logic [31:0]        pc, pc_nx, ir, a_q, b_q, imm_q, alu_q, mdr;
    logic [31:0]        alu_y, pc_plus4, br_target, j_target;
    logic [31:0]        rf_rd1, rf_rd2, rf_wd, wdata_q;
    logic [4:0]         rf_wa;
    logic               rf_we, retire, legal, wen_q, oen_q;
    logic [DADDR_W-1:0] dmem_a_q;
    logic [5:0]         op, funct;
    logic [4:0]         rs, rt, rd, shamt;

    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign shamt = ir[10:6];
    assign funct = ir[5:0];
    assign legal = is_legal(op, funct);

    assign pc_plus4  = pc + 32'd4;
    assign br_target = pc_plus4 + {imm_q[29:0], 2'b00};
    assign j_target  = {pc_plus4[31:28], ir[25:0], 2'b00};

    mc_regfile u_rf (
        .clk (clk),
        .rst_n (rst_n),
        .ra1 (rs),
        .ra2 (rt),
        .rd1 (rf_rd1),
        .rd2 (rf_rd2),
        .we  (rf_we),
        .wa  (rf_wa),
        .wd  (rf_wd)
    );

    always_comb begin
        alu_y = '0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_y = a_q + b_q;
                    FN_SUB:  alu_y = a_q - b_q;
                    FN_AND:  alu_y = a_q & b_q;
                    FN_OR:   alu_y = a_q | b_q;
                    FN_SLT:  alu_y = {31'b0, $signed(a_q) < $signed(b_q)};
                    FN_SLL:  alu_y = b_q << shamt;
                    FN_SRL:  alu_y = b_q >> shamt;
                    default: alu_y = '0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: alu_y = a_q + imm_q;
            default: alu_y = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        retire   = 1'b0;
        rf_we    = 1'b0;
        rf_wa    = 5'd0;
        rf_wd    = '0;
        case (state)
            S_FETCH:  if (bus.imem_valid) state_nx = S_DECODE;
            S_DECODE: state_nx = S_EXEC;
            S_EXEC: begin
                // illegal encodings retire as a no-op so the program keeps flowing
                if (!legal) begin
                    pc_nx    = pc_plus4;
                    retire   = 1'b1;
                    state_nx = S_FETCH;
                end else begin
                    case (op)
                        OP_BEQ, OP_BNE: begin
                            pc_nx    = ((a_q == b_q) == (op == OP_BEQ)) ? br_target : pc_plus4;
                            retire   = 1'b1;
                            state_nx = S_FETCH;
                        end
                        OP_J: begin
                            pc_nx    = j_target;
                            retire   = 1'b1;
                            state_nx = S_FETCH;
                        end
                        OP_LW, OP_SW: state_nx = S_MEM;
                        OP_RTYPE: begin
                            if (funct == FN_JR) begin
                                pc_nx    = a_q;
                                retire   = 1'b1;
                                state_nx = S_FETCH;
                            end else begin
                                state_nx = S_WB;
                            end
                        end
                        default: state_nx = S_WB;
                    endcase
                end
            end
            S_MEM: begin
                if (bus.dmem_ready) begin
                    if (op == OP_LW) begin
                        state_nx = S_WB;
                    end else begin
                        pc_nx    = pc_plus4;
                        retire   = 1'b1;
                        state_nx = S_FETCH;
                    end
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                rf_wa    = (op == OP_RTYPE) ? rd : (op == OP_JAL) ? 5'd31 : rt;
                rf_wd    = (op == OP_LW) ? mdr : (op == OP_JAL) ? pc_plus4 : alu_q;
                pc_nx    = (op == OP_JAL) ? j_target : pc_plus4;
                retire   = 1'b1;
                state_nx = S_FETCH;
            end
            default: state_nx = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            instret  <= '0;
            illegal  <= 1'b0;
            ir       <= '0;
            a_q      <= '0;
            b_q      <= '0;
            imm_q    <= '0;
            alu_q    <= '0;
            mdr      <= '0;
            wen_q    <= 1'b1;
            oen_q    <= 1'b1;
            dmem_a_q <= '0;
            wdata_q  <= '0;
        end else begin
            pc <= pc_nx;
            if (retire) instret <= instret + CNT_W'(1);
            if (state == S_FETCH && bus.imem_valid) ir <= bus.imem_rdata;
            if (state == S_DECODE) begin
                a_q   <= rf_rd1;
                b_q   <= rf_rd2;
                imm_q <= {{16{ir[15]}}, ir[15:0]};
            end
            if (state == S_EXEC) begin
                alu_q <= alu_y;
                if (!legal) illegal <= 1'b1;
                if (legal && (op == OP_LW || op == OP_SW)) begin
                    dmem_a_q <= alu_y[DADDR_W+1:2];
                    wdata_q  <= b_q;
                    oen_q    <= (op != OP_LW);
                    wen_q    <= (op != OP_SW);
                end
            end
            if (state == S_MEM && bus.dmem_ready) begin
                wen_q <= 1'b1;
                oen_q <= 1'b1;
                mdr   <= bus.dmem_rdata;
            end
        end
    end

    // rst_n gates the request so nothing is fetched while reset is held
    assign bus.imem_req   = (state == S_FETCH) && rst_n;
    assign bus.imem_addr  = pc;
    assign bus.dmem_wen   = wen_q;
    assign bus.dmem_oen   = oen_q;
    assign bus.dmem_cen   = wen_q & oen_q;
    assign bus.dmem_a     = dmem_a_q;
    assign bus.dmem_wdata = wdata_q;
endmodule
